// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell, one bit per clock, LSB first.
// Latency: start sampled at E0, result valid and done pulsed in the cycle after E_WIDTH.
// Handshake: start is accepted only in IDLE or DONE and is ignored while busy.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] work;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic sum_bit;
    logic carry_nxt;

    // Single full-adder cell working on the current LSBs of the operand shift registers.
    always_comb begin
        sum_bit   = sh_a[0] ^ sh_b[0] ^ carry;
        carry_nxt = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
    end

    // Control FSM and datapath; subtraction is a + ~b + 1 via inverted B and a preset carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            sh_a     <= '0;
            sh_b     <= '0;
            work     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                        work  <= '0;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    work  <= {sum_bit, work[WIDTH-1:1]};
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    carry <= carry_nxt;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        // At the MSB step, carry still holds the carry into the MSB.
                        result   <= {sum_bit, work[WIDTH-1:1]};
                        cout     <= carry_nxt;
                        overflow <= carry ^ carry_nxt;
                        cnt      <= '0;
                        state    <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Status outputs decode straight from the state, so busy and done are mutually exclusive.
    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: directed WIDTH=8 vectors plus an exhaustive WIDTH=4 sweep.
// Outputs are compared every negedge against an arithmetic model and a result scoreboard.
// Inputs are driven 1 time unit after the rising edge.
module tb_serial_addsub;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8, overflow8;
    logic [7:0] result8;

    logic       start4 = 1'b0, sub4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, cout4, overflow4;
    logic [3:0] result4;

    int checks = 0;
    int errors = 0;

    logic [9:0] q8[$];
    logic [5:0] q4[$];
    logic [9:0] hold8 = '0;
    logic [5:0] hold4 = '0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .cout(cout8), .overflow(overflow8)
    );

    serial_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .result(result4), .cout(cout4), .overflow(overflow4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Plain integer arithmetic: unsigned for the carry, signed range test for overflow.
    function automatic void model(input int w, input int ma, input int mb, input bit ms,
                                  output int r, output bit c, output bit o);
        int mask, half, sa, sb, t;
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        if (ms) begin
            r = (ma - mb) & mask;
            c = (ma >= mb);
        end else begin
            r = (ma + mb) & mask;
            c = ((ma + mb) > mask);
        end
        sa = (ma >= half) ? ma - 2 * half : ma;
        sb = (mb >= half) ? mb - 2 * half : mb;
        t  = ms ? sa - sb : sa + sb;
        o  = (t < -half) || (t > half - 1);
    endfunction

    // Compare process: exclusivity, completion values from the scoreboard, held outputs.
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy8_done8_excl", 32'(busy8 & done8), 32'd0);
            if (done8) begin
                if (q8.size() == 0) chk("done8_unexpected", 32'(done8), 32'd0);
                else hold8 = q8.pop_front();
            end
            chk("out8_vs_model", 32'({result8, cout8, overflow8}), 32'(hold8));
            chk("busy4_done4_excl", 32'(busy4 & done4), 32'd0);
            if (done4) begin
                if (q4.size() == 0) chk("done4_unexpected", 32'(done4), 32'd0);
                else hold4 = q4.pop_front();
            end
            chk("out4_vs_model", 32'({result4, cout4, overflow4}), 32'(hold4));
        end
    end

    task automatic push8(input logic [7:0] ta, input logic [7:0] tb, input logic ts);
        int r; bit c, o;
        model(8, int'(ta), int'(tb), ts, r, c, o);
        q8.push_back({r[7:0], c, o});
    endtask

    // Waits at negedges for done8; returns negedges elapsed and how many showed busy.
    task automatic wait_done8(input string nm, output int n, output int nb);
        bit seen;
        n = 0; nb = 0; seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (busy8) nb++;
            if (done8) seen = 1;
        end
        if (!seen) chk({nm, "_timeout"}, 32'(seen), 32'd1);
    endtask

    task automatic op8(input string nm, input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                       input logic [7:0] er, input logic ec, input logic eo);
        int r, n, nb; bit c, o;
        model(8, int'(ta), int'(tb), ts, r, c, o);
        chk({nm, "_model_r"}, 32'(r), 32'(er));
        chk({nm, "_model_c"}, 32'(c), 32'(ec));
        chk({nm, "_model_o"}, 32'(o), 32'(eo));
        push8(ta, tb, ts);
        a8 = ta; b8 = tb; sub8 = ts; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        wait_done8(nm, n, nb);
        chk({nm, "_latency"}, 32'(n), 32'd9);
        chk({nm, "_busy_cycles"}, 32'(nb), 32'd8);
        chk({nm, "_result"}, 32'(result8), 32'(er));
        chk({nm, "_cout"}, 32'(cout8), 32'(ec));
        chk({nm, "_ovf"}, 32'(overflow8), 32'(eo));
        @(negedge clk);
        chk({nm, "_done_width"}, 32'(done8), 32'd0);
    endtask

    initial begin
        int n, nb, extra, r; bit c, o;

        #1;
        chk("rst_result8", 32'(result8), 32'd0);
        chk("rst_flags8", 32'({busy8, done8, cout8, overflow8}), 32'd0);
        chk("rst_flags4", 32'({busy4, done4, cout4, overflow4, result4}), 32'd0);
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b0;

        op8("add_05_03", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
        op8("add_FF_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("add_7F_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        op8("sub_03_05", 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0);
        op8("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        op8("sub_05_05", 8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0);

        // start pulsed with new operands mid-RUN must be ignored.
        push8(8'h05, 8'h03, 1'b0);
        a8 = 8'h05; b8 = 8'h03; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 a8 = 8'hAA; b8 = 8'h11; sub8 = 1'b1; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        wait_done8("midrun", n, nb);
        chk("midrun_result", 32'(result8), 32'h08);
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) extra++;
        end
        chk("midrun_no_extra_op", 32'(extra), 32'd0);

        // start held through DONE: second op is accepted back-to-back.
        push8(8'h10, 8'h20, 1'b0);
        push8(8'h10, 8'h20, 1'b1);
        a8 = 8'h10; b8 = 8'h20; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1 sub8 = 1'b1;
        wait_done8("held_first", n, nb);
        chk("held_first_result", 32'(result8), 32'h30);
        @(posedge clk);
        #1 start8 = 1'b0;
        wait_done8("held_second", n, nb);
        chk("held_second_gap", 32'(n), 32'd9);
        chk("held_second_result", 32'({result8, cout8, overflow8}), 32'({8'hF0, 1'b0, 1'b0}));

        // Asynchronous reset at bit 4 of an op: outputs clear at once, op abandoned.
        a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        q8.delete(); q4.delete(); hold8 = '0; hold4 = '0;
        #1;
        chk("arst_result8", 32'(result8), 32'd0);
        chk("arst_flags8", 32'({busy8, done8, cout8, overflow8}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) extra++;
        end
        chk("arst_no_done", 32'(extra), 32'd0);
        op8("post_rst_12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

        // Pin the 4-bit model, then sweep every operand pair and operation.
        model(4, 15, 1, 1'b0, r, c, o);
        chk("model4_F_1", 32'({r[3:0], c, o}), 32'({4'h0, 1'b1, 1'b0}));
        model(4, 8, 1, 1'b1, r, c, o);
        chk("model4_8_m1", 32'({r[3:0], c, o}), 32'({4'h7, 1'b1, 1'b1}));
        for (int i = 0; i < 512; i++) begin
            bit seen;
            int k;
            model(4, i & 15, (i >> 4) & 15, i[8], r, c, o);
            q4.push_back({r[3:0], c, o});
            a4 = 4'(i & 15); b4 = 4'((i >> 4) & 15); sub4 = i[8]; start4 = 1'b1;
            @(posedge clk);
            #1 start4 = 1'b0;
            seen = 0; k = 0;
            while (!seen && k < 20) begin
                @(negedge clk);
                k++;
                if (done4) seen = 1;
            end
            if (!seen) chk("sweep4_timeout", 32'(seen), 32'd1);
        end
        @(negedge clk);
        chk("sweep4_queue_drained", 32'(q4.size()), 32'd0);
        chk("dir8_queue_drained", 32'(q8.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
